seq110_stream_ctrl: RTL

- Sequencer for the shared "110" sequence-detector datapath.
- Accepts parallel WIDTH-bit words over a valid/ready handshake and shifts them MSB-first, one bit per clock, into a Moore 110-detector core.
- Counts "110" completions per word and returns the count over a second valid/ready handshake.
- Sits between a word-oriented producer and any consumer of per-word match statistics.

---
 rtl/seq110_pkg.sv | 19 +
 rtl/seq110_stream_ctrl_if.sv | 24 ++
 rtl/seq110_core.sv | 44 ++++
 rtl/seq110_stream_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/seq110_pkg.sv
// Shared encodings for the "110" detector core and its stream controller.
package seq110_pkg;

  // Moore detector states: S1 = saw "1", S2 = saw "11", S3 = just completed "110".
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/seq110_stream_ctrl_if.sv
// Word-in / count-out handshake bundle for seq110_stream_ctrl.
// master = producer+consumer side, slave = the controller.
interface seq110_stream_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_cont;
  logic             in_ready;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             out_ready;

  modport master (
    output in_valid, in_data, in_cont, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, in_cont, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/seq110_core.sv
// Moore "110" sequence detector. clr beats en; hit flags the bit that
// completes "110" (combinational, only meaningful while en is high).
module seq110_core
  import seq110_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       a,
  output logic [1:0] state,
  output logic       hit,
  output logic       w
);

  det_state_e state_q, state_d;

  // Next-state: synchronous clear first, otherwise advance on enabled bits.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      case (state_q)
        S0: state_d = a ? S1 : S0;
        S1: state_d = a ? S2 : S0;
        S2: state_d = a ? S2 : S3;
        S3: state_d = a ? S1 : S0;
        default: state_d = S0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  assign state = state_q;
  assign hit   = en & (state_q == S2) & ~a;
  assign w     = (state_q == S3);

endmodule

// File: rtl/seq110_stream_ctrl.sv
// Stream controller: accepts a word, feeds it MSB-first into the 110 detector
// one bit per clock, and returns the number of completions in that word.
module seq110_stream_ctrl
  import seq110_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  seq110_stream_ctrl_if.slave s,
  output logic               busy,
  output logic [1:0]         det_state
);

  ctrl_state_e      st_q, st_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic core_clr, core_en, core_a, core_hit, core_w_unused;
  logic [1:0] core_state;

  // Core is only stepped while shifting; it sees the current MSB.
  assign core_en = (st_q == SHIFT);
  assign core_a  = shreg_q[WIDTH-1];

  seq110_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (core_clr),
    .en    (core_en),
    .a     (core_a),
    .state (core_state),
    .hit   (core_hit),
    .w     (core_w_unused)
  );

  // Controller next-state and datapath updates.
  always_comb begin
    st_d     = st_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    count_d  = count_q;
    core_clr = 1'b0;
    case (st_q)
      IDLE: begin
        if (s.in_valid) begin
          shreg_d  = s.in_data;
          bitcnt_d = CNT_W'(WIDTH - 1);
          count_d  = '0;
          core_clr = ~s.in_cont;
          st_d     = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (core_hit) count_d = count_q + CNT_W'(1);
        if (bitcnt_q == '0) st_d = DONE;
        else                bitcnt_d = bitcnt_q - CNT_W'(1);
      end
      DONE: begin
        if (s.out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      count_q  <= '0;
    end else begin
      st_q     <= st_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      count_q  <= count_d;
    end
  end

  // in_ready is masked by reset so nothing is accepted during reset.
  assign s.in_ready  = (st_q == IDLE) & ~reset;
  assign s.out_valid = (st_q == DONE);
  assign s.out_count = (st_q == DONE) ? count_q : '0;
  assign busy        = (st_q != IDLE);
  assign det_state   = core_state;

endmodule
